// File: rtl/bp_be_dcache_pkg.sv
// Shared D$ request types: opcode enum, packet struct macro and opcode classification helpers.
`ifndef BP_BE_DCACHE_PKG_SV
`define BP_BE_DCACHE_PKG_SV

`define BP_BE_DCACHE_PKT_WIDTH(addr_w, data_w) (4 + (addr_w) + (data_w))

`define DECLARE_BP_BE_DCACHE_PKT_S(addr_w, data_w) \
  typedef struct packed { \
    bp_be_dcache_opcode_e   opcode; \
    logic [(addr_w)-1:0]    addr; \
    logic [(data_w)-1:0]    data; \
  } bp_be_dcache_pkt_s

package bp_be_dcache_pkg;

  typedef enum logic [3:0] {
    e_dcache_op_lb  = 4'h0,
    e_dcache_op_lh  = 4'h1,
    e_dcache_op_lw  = 4'h2,
    e_dcache_op_ld  = 4'h3,
    e_dcache_op_lbu = 4'h4,
    e_dcache_op_lhu = 4'h5,
    e_dcache_op_lwu = 4'h6,
    e_dcache_op_sb  = 4'h8,
    e_dcache_op_sh  = 4'h9,
    e_dcache_op_sw  = 4'ha,
    e_dcache_op_sd  = 4'hb
  } bp_be_dcache_opcode_e;

  function automatic logic is_legal(input bp_be_dcache_opcode_e op);
    logic [3:0] raw;
    raw = op;
    return (raw != 4'h7) && (raw <= 4'hb);
  endfunction

  // 0111 has opcode[3]==0 but is illegal, so it never counts as a load
  function automatic logic is_load(input bp_be_dcache_opcode_e op);
    logic [3:0] raw;
    raw = op;
    return ~raw[3] && (raw != 4'h7);
  endfunction

endpackage

`endif

// File: rtl/bp_be_dcache_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding loads; caller never pushes when full or pops when empty.
module bp_be_dcache_arb_id_fifo #(
  parameter int els_p   = 4,
  parameter int width_p = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [width_p-1:0]       data_i,
  input  logic                     pop_i,
  output logic [width_p-1:0]       data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(els_p):0]   count_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp:0]   count_q, count_d;

  // Power-of-two depth lets the pointers wrap naturally
  always_comb begin
    wptr_d  = push_i ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop_i  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (count_q == (ptr_w_lp+1)'(els_p));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/bp_be_dcache_req_arbiter.sv
// Arbitrates BE requesters onto the single D$ port and steers in-order load data back.
// Define BP_BE_DCACHE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bp_be_dcache_req_arbiter
  import bp_be_dcache_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int addr_width_p  = 39,
  parameter int data_width_p  = 64,
  parameter int id_fifo_els_p = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [4*num_req_p-1:0]                req_opcode_i,
  input  logic [addr_width_p*num_req_p-1:0]     req_addr_i,
  input  logic [data_width_p*num_req_p-1:0]     req_data_i,
  output logic [num_req_p-1:0]                  req_ready_o,
  output logic                                  dcache_pkt_v_o,
  output logic [`BP_BE_DCACHE_PKT_WIDTH(addr_width_p, data_width_p)-1:0] dcache_pkt_o,
  input  logic                                  dcache_ready_i,
  input  logic                                  dcache_v_i,
  input  logic [data_width_p-1:0]               dcache_data_i,
  output logic [num_req_p-1:0]                  resp_v_o,
  output logic [data_width_p-1:0]               resp_data_o,
  output logic                                  error_o
);

  localparam int id_w_lp = $clog2(num_req_p);

  `DECLARE_BP_BE_DCACHE_PKT_S(addr_width_p, data_width_p);

  bp_be_dcache_opcode_e     op       [num_req_p];
  logic [num_req_p-1:0]     elig;
  logic                     fifo_full, fifo_empty;
  logic [id_w_lp-1:0]       fifo_head;
  logic [$clog2(id_fifo_els_p):0] fifo_count;
  logic                     gnt_found;
  logic [id_w_lp-1:0]       gnt_idx;
  bp_be_dcache_pkt_s        gnt_pkt, pkt_q;
  logic                     load_en, accept, gnt_legal, push, pop;
  logic                     pkt_v_q, pkt_v_d, err_q, err_d;

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      op[i]   = bp_be_dcache_opcode_e'(req_opcode_i[4*i +: 4]);
      elig[i] = req_v_i[i] & (~is_load(op[i]) | ~fifo_full);
    end
  end

`ifdef BP_BE_DCACHE_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = num_req_p-1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = id_w_lp'(i);
      end
    end
  end
`else
  logic [id_w_lp-1:0] rr_q, rr_d;

  // Walk offsets from farthest to nearest so the nearest eligible after rr wins
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = num_req_p; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % num_req_p;
      if (elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = id_w_lp'(idx);
      end
    end
  end

  assign rr_d = accept ? gnt_idx : rr_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rr_q <= id_w_lp'(num_req_p-1);
    else            rr_q <= rr_d;
  end
`endif

  assign load_en = ~pkt_v_q | dcache_ready_i;
  assign accept  = load_en & gnt_found;

  always_comb begin
    gnt_pkt = '0;
    for (int i = 0; i < num_req_p; i++) begin
      req_ready_o[i] = accept & (gnt_idx == id_w_lp'(i));
      resp_v_o[i]    = pop & (fifo_head == id_w_lp'(i));
      if (gnt_idx == id_w_lp'(i)) begin
        gnt_pkt.opcode = op[i];
        gnt_pkt.addr   = req_addr_i[addr_width_p*i +: addr_width_p];
        gnt_pkt.data   = req_data_i[data_width_p*i +: data_width_p];
      end
    end
  end

  assign gnt_legal = is_legal(gnt_pkt.opcode);
  assign push      = accept & is_load(gnt_pkt.opcode);
  assign pop       = dcache_v_i & ~fifo_empty;
  assign pkt_v_d   = load_en ? (accept & gnt_legal) : pkt_v_q;
  assign err_d     = (accept & ~gnt_legal) | (dcache_v_i & (fifo_count == '0));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_v_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pkt_v_q <= pkt_v_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept & gnt_legal) pkt_q <= gnt_pkt;
  end

  bp_be_dcache_arb_id_fifo #(
    .els_p   (id_fifo_els_p),
    .width_p (id_w_lp)
  ) id_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .data_i    (gnt_idx),
    .pop_i     (pop),
    .data_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign dcache_pkt_v_o = pkt_v_q;
  assign dcache_pkt_o   = pkt_q;
  assign resp_data_o    = dcache_data_i;
  assign error_o        = err_q;

endmodule

// File: tb/tb_bp_be_dcache_req_arbiter.sv
// Randomized scoreboard bench for bp_be_dcache_req_arbiter with a queue-based reference model.
module tb_bp_be_dcache_req_arbiter;

  localparam int N   = 3;
  localparam int AW  = 39;
  localparam int DW  = 64;
  localparam int ELS = 4;
  localparam int PW  = 4 + AW + DW;
`ifdef BP_BE_DCACHE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_v_i = '0;
  logic [4*N-1:0]  req_opcode_i = '0;
  logic [AW*N-1:0] req_addr_i = '0;
  logic [DW*N-1:0] req_data_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            dcache_pkt_v_o;
  logic [PW-1:0]   dcache_pkt_o;
  logic            dcache_ready_i = 1'b0;
  logic            dcache_v_i = 1'b0;
  logic [DW-1:0]   dcache_data_i = '0;
  logic [N-1:0]    resp_v_o;
  logic [DW-1:0]   resp_data_o;
  logic            error_o;

  always #5 clk = ~clk;

  bp_be_dcache_req_arbiter #(
    .num_req_p(N), .addr_width_p(AW), .data_width_p(DW), .id_fifo_els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v_i), .req_opcode_i(req_opcode_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .dcache_pkt_v_o(dcache_pkt_v_o), .dcache_pkt_o(dcache_pkt_o), .dcache_ready_i(dcache_ready_i),
    .dcache_v_i(dcache_v_i), .dcache_data_i(dcache_data_i),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .error_o(error_o)
  );

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_pkt_q[$];
  int            exp_resp_q[$];
  int            m_fifo[$];
  int            m_rr;
  bit            m_pkt_v;
  bit            m_err;
  bit            model_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_legal(input logic [3:0] op);
    return (op != 4'h7) && (op <= 4'hb);
  endfunction

  function automatic bit op_load(input logic [3:0] op);
    return op <= 4'h6;
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] legal [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'ha, 4'hb};
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(0, 15));
    return legal[$urandom_range(0, 10)];
  endfunction

  task automatic model_reset();
    m_rr    = N - 1;
    m_pkt_v = 1'b0;
    m_err   = 1'b0;
    m_fifo.delete();
    exp_pkt_q.delete();
    exp_resp_q.delete();
  endtask

  // Reference: evaluated mid-cycle with inputs stable, advances one clock of abstract state
  task automatic model_step();
    int         gnt;
    int         i;
    bit         full, load_en;
    logic [3:0] op;
    logic [N-1:0] exp_rdy;
    chk("pkt_v", dcache_pkt_v_o, m_pkt_v);
    chk("error", error_o, m_err);
    full    = (m_fifo.size() == ELS);
    load_en = !m_pkt_v || dcache_ready_i;
    gnt     = -1;
    if (load_en) begin
      for (int k = 1; k <= N; k++) begin
        i  = FIXED ? k - 1 : (m_rr + k) % N;
        op = req_opcode_i[4*i +: 4];
        if (gnt < 0 && req_v_i[i] && !(op_load(op) && full)) gnt = i;
      end
    end
    exp_rdy = '0;
    if (gnt >= 0) exp_rdy[gnt] = 1'b1;
    chk("req_ready", req_ready_o, exp_rdy);
    m_err = 1'b0;
    if (dcache_v_i) begin
      if (m_fifo.size() == 0) m_err = 1'b1;
      else void'(m_fifo.pop_front());
    end
    op = '0;
    if (gnt >= 0) begin
      op   = req_opcode_i[4*gnt +: 4];
      m_rr = gnt;
      if (!op_legal(op)) m_err = 1'b1;
      else if (op_load(op)) begin
        m_fifo.push_back(gnt);
        exp_resp_q.push_back(gnt);
      end
    end
    if (load_en) begin
      m_pkt_v = (gnt >= 0) && op_legal(op);
      if (m_pkt_v) exp_pkt_q.push_back({op, req_addr_i[AW*gnt +: AW], req_data_i[DW*gnt +: DW]});
    end
  endtask

  always @(negedge clk) begin
    if (model_en) begin
      #1;
      model_step();
    end
  end

  // Monitor: pops expectations whenever the DUT presents a packet or load response
  always @(negedge clk) begin
    logic [N-1:0] exp_v;
    int id;
    if (dcache_pkt_v_o && dcache_ready_i) begin
      if (exp_pkt_q.size() == 0) chk("pkt_unexpected", dcache_pkt_o, '0);
      else chk("pkt", dcache_pkt_o, exp_pkt_q.pop_front());
    end
    if (dcache_v_i) begin
      exp_v = '0;
      if (exp_resp_q.size() != 0) begin
        id = exp_resp_q.pop_front();
        exp_v[id] = 1'b1;
        chk("resp_data", resp_data_o, dcache_data_i);
      end
      chk("resp_v", resp_v_o, exp_v);
    end
  end

  task automatic set_req(input int i, input bit v, input logic [3:0] op,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_v_i[i]              = v;
    req_opcode_i[4*i +: 4]  = op;
    req_addr_i[AW*i +: AW]  = a;
    req_data_i[DW*i +: DW]  = d;
  endtask

  task automatic idle();
    req_v_i    = '0;
    dcache_v_i = 1'b0;
  endtask

  task automatic run(input int n, input int pv, input int prdy, input int pdv);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 99) < pv, rand_op(), AW'({$urandom, $urandom}), {$urandom, $urandom});
      dcache_ready_i = $urandom_range(0, 99) < prdy;
      dcache_v_i     = $urandom_range(0, 99) < pdv;
      dcache_data_i  = {$urandom, $urandom};
    end
  endtask

  initial begin
    model_reset();
    dcache_v_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pkt_v", dcache_pkt_v_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    chk("rst_resp_v", resp_v_o, '0);
    dcache_v_i = 1'b0;
    reset_n    = 1'b1;
    model_en   = 1'b1;

    // lw from req0 and sd from req1 together: req0 first, then req1
    @(posedge clk); #1;
    set_req(0, 1'b1, 4'h2, 39'h100, 64'h0);
    set_req(1, 1'b1, 4'hb, 39'h200, 64'hdead_beef_0000_0001);
    dcache_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    idle();
    set_req(1, 1'b1, 4'hf, 39'h300, 64'h5);
    @(posedge clk); #1;
    idle();
    dcache_v_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle();

    run(300, 70, 70, 30);
    run(200, 90, 90, 5);
    run(200, 80, 25, 40);
    run(100, 60, 80, 0);

    // Async reset with loads outstanding
    @(posedge clk); #2;
    model_en   = 1'b0;
    idle();
    dcache_v_i = 1'b1;
    reset_n    = 1'b0;
    #1;
    chk("mid_rst_pkt_v", dcache_pkt_v_o, 1'b0);
    chk("mid_rst_error", error_o, 1'b0);
    chk("mid_rst_resp_v", resp_v_o, '0);
    model_reset();
    @(posedge clk); #1;
    reset_n    = 1'b1;
    model_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    dcache_v_i = 1'b0;

    run(300, 70, 70, 30);

    @(posedge clk); #1;
    idle();
    dcache_ready_i = 1'b1;
    dcache_v_i     = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    dcache_v_i = 1'b0;
    @(negedge clk); #2;
    chk("pkt_q_drained", 128'(exp_pkt_q.size()), 128'd0);
    chk("resp_q_drained", 128'(exp_resp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
